rx_frame_controller: RTL

Sequencing controller for the UART receive path. It owns the receive state machine and the baud timer, decides when the incoming line is sampled, and assembles LSB-first frames (start, data, optional parity, stop). It checks parity and stop bit, and hands each byte to the consumer over a valid/ready handshake, flagging overrun. It sits between the `serial_in` pin and the byte-level consumer, replacing free-running strobe generation with a single authoritative sequencer.

---
 rtl/uart_pkg.sv | 16 +
 rtl/rx_frame_controller_if.sv | 31 +++
 rtl/rx_bit_timer.sv | 44 ++++
 rtl/rx_frame_controller.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive-path types and defaults.
// Holds the receive FSM state enum and the frame-size constants.
package uart_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;
    localparam int UART_MAX_DATA_BITS        = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/rx_frame_controller_if.sv
// Byte handoff bundle between the receive controller and its consumer.
// master: drives rx_data/rx_valid/flags, takes rx_ready; slave: mirror.
interface rx_frame_controller_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_MAX_DATA_BITS
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_error;
    logic                 framing_error;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_error,
        output framing_error,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_error,
        input  framing_error,
        output rx_ready
    );

endinterface

// File: rtl/rx_bit_timer.sv
// Baud down-counter: half-bit load on a start edge, full-bit reload per sample.
// Ports: clk, reset_n, active, load_half, load_full -> sample_tick.
module rx_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    input  logic load_half,
    input  logic load_full,
    output logic sample_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sample_tick = active && (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load_half) begin
            cnt_d = HALF;
        end else if (load_full) begin
            cnt_d = FULL;
        end else if (active && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_frame_controller.sv
// UART receive sequencer: sync, FSM, shift register, output/handshake regs.
// Ports: clk, reset_n, serial_in, rx (master bundle), overrun_error, busy.
module rx_frame_controller
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_MAX_DATA_BITS,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   serial_in,
    rx_frame_controller_if.master  rx,
    output logic                   overrun_error,
    output logic                   busy
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_t state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rx_sync;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 tick;
    logic                 load_half;
    logic                 commit;

    assign rx_sync = sync_q[1];

    rx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .active     (state_q != IDLE),
        .load_half  (load_half),
        .load_full  (tick),
        .sample_tick(tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        perr_d    = perr_q;
        load_half = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_sync) begin
                    state_d   = START;
                    load_half = 1'b1;
                    perr_d    = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    // line back high at mid-start: glitch, not a frame
                    if (rx_sync) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d   = {rx_sync, shreg_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    perr_d  = ((^shreg_q) ^ rx_sync) != PARITY_ODD[0];
                    state_d = STOP;
                end
            end
            STOP: begin
                // leave mid-stop-bit so a following start edge is seen early
                if (tick) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ovr_d   = 1'b0;
        if (valid_q && rx.rx_ready) begin
            valid_d = 1'b0;
        end
        if (commit) begin
            if (!valid_q || rx.rx_ready) begin
                data_d  = shreg_q;
                pe_d    = perr_q;
                fe_d    = !rx_sync;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], serial_in};
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            perr_q    <= perr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx.rx_data       = data_q;
    assign rx.rx_valid      = valid_q;
    assign rx.parity_error  = pe_q;
    assign rx.framing_error = fe_q;
    assign overrun_error    = ovr_q;
    assign busy             = (state_q != IDLE);

endmodule
